// File: rtl/cgra_fu_pkg.sv
// Shared types and constants for the s_tile functional units.
// Holds the accumulator FSM state encoding and the default group length.
package cgra_fu_pkg;

  typedef enum logic [1:0] {ACC_IDLE, ACC_ACCUM, ACC_HOLD} acc_state_t;

  localparam int ACC_LEN_DEFAULT = 1;

endpackage

// File: rtl/accumulator_fu.sv
// Reduction stage after the multiplier FU: sums acc_len unsigned products per group.
// Define ACCUMULATOR_FU_SAT_EN for saturating arithmetic; default build wraps.
module accumulator_fu
  import cgra_fu_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 on_off,
  input  logic [CNT_WIDTH-1:0] acc_len,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overflow,
  output logic                 drop
);

  localparam logic [CNT_WIDTH-1:0] LEN_ONE = CNT_WIDTH'(ACC_LEN_DEFAULT);

  acc_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;
  logic                 drop_q, drop_d;

  logic [ACC_WIDTH-1:0] in_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] sum_acc;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 accept;
  logic                 start_grp;

  assign in_ready  = (state_q != ACC_HOLD) | out_ready;
  assign out_valid = (state_q == ACC_HOLD);
  assign out_data  = acc_q;
  assign overflow  = ovf_q;
  assign drop      = drop_q;

  assign accept  = in_valid & in_ready & on_off;
  assign len_eff = (acc_len == '0) ? LEN_ONE : acc_len;
  assign cnt_inc = cnt_q + LEN_ONE;

  always_comb begin
    in_ext = '0;
    in_ext[IN_WIDTH-1:0] = in_data;
    sum   = {1'b0, acc_q} + {1'b0, in_ext};
    carry = sum[ACC_WIDTH];
`ifdef ACCUMULATOR_FU_SAT_EN
    // Once clamped, any further nonzero beat carries again, so the clamp holds for the group.
    sum_acc = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    sum_acc = sum[ACC_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q | (in_valid & on_off & ~in_ready);
    start_grp = 1'b0;

    case (state_q)
      ACC_IDLE: begin
        start_grp = accept;
      end
      ACC_ACCUM: begin
        if (accept) begin
          acc_d = sum_acc;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = ACC_HOLD;
        end
      end
      ACC_HOLD: begin
        if (out_ready) begin
          state_d   = ACC_IDLE;
          start_grp = accept;
        end
      end
      default: state_d = ACC_IDLE;
    endcase

    // A beat landing on the result handshake opens the next group without a bubble.
    if (start_grp) begin
      acc_d   = in_ext;
      cnt_d   = LEN_ONE;
      len_d   = len_eff;
      ovf_d   = 1'b0;
      state_d = (len_eff == LEN_ONE) ? ACC_HOLD : ACC_ACCUM;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_ONE;
      ovf_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_accumulator_fu.sv
// Self-checking bench for accumulator_fu: scoreboard of expected group results plus directed checks.
// A second 16-bit instance exercises wrap/saturation (ACCUMULATOR_FU_SAT_EN).
module tb_accumulator_fu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        on_off = 1'b1;
  logic [3:0]  acc_len = 4'd1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, overflow, drop;
  logic [23:0] out_data;
  logic        n_in_ready, n_out_valid, n_overflow, n_drop;
  logic [15:0] n_out_data;

  typedef struct packed {
    logic [23:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_count = 0;
  int   hs_before;

`ifdef ACCUMULATOR_FU_SAT_EN
  localparam logic [15:0] NARROW_EXP = 16'hFFFF;
`else
  localparam logic [15:0] NARROW_EXP = 16'h0001;
`endif

  always #5 clk = ~clk;

  accumulator_fu #(.IN_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .on_off(on_off), .acc_len(acc_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .overflow(overflow), .drop(drop)
  );

  accumulator_fu #(.IN_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(4)) dut_narrow (
    .clk(clk), .reset_n(reset_n), .on_off(on_off), .acc_len(acc_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_data(n_out_data),
    .overflow(n_overflow), .drop(n_drop)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic oo,
                               input logic [3:0] len, input logic rdy);
    in_valid  = v;
    in_data   = d;
    on_off    = oo;
    acc_len   = len;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  // Handshake monitor: sampled mid-cycle, the handshake completes at the next rising edge.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      hs_count++;
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected", 32'(out_data), 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sb_data", 32'(out_data), 32'(e.data));
        checkOutput("sb_ovf", 32'(overflow), 32'(e.ovf));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drop", 32'(drop), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat groups, one cycle latency, back-to-back
    sb_q.push_back('{data: 24'd5, ovf: 1'b0});
    sb_q.push_back('{data: 24'd7, ovf: 1'b0});
    applyStimulus(1'b1, 16'd5, 1'b1, 4'd1, 1'b1);
    checkOutput("t1_lat5_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_lat5_data", 32'(out_data), 32'd5);
    applyStimulus(1'b1, 16'd7, 1'b1, 4'd1, 1'b1);
    checkOutput("t1_lat7_valid", 32'(out_valid), 32'd1);
    checkOutput("t1_lat7_data", 32'(out_data), 32'd7);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd1, 1'b1);
    checkOutput("t1_idle_valid", 32'(out_valid), 32'd0);

    // Four-beat group, exactly one result pulse
    hs_before = hs_count;
    sb_q.push_back('{data: 24'd10, ovf: 1'b0});
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 16'(i), 1'b1, 4'd4, 1'b1);
      checkOutput($sformatf("t2_valid_%0d", i), 32'(out_valid), (i == 4) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd4, 1'b1);
    checkOutput("t2_valid_after", 32'(out_valid), 32'd0);
    checkOutput("t2_pulses", 32'(hs_count - hs_before), 32'd1);

    // on_off freeze mid-group; acc_len change mid-group ignored
    sb_q.push_back('{data: 24'd60, ovf: 1'b0});
    applyStimulus(1'b1, 16'd10, 1'b1, 4'd3, 1'b1);
    applyStimulus(1'b1, 16'd20, 1'b1, 4'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'd999, 1'b0, 4'd1, 1'b1);
      checkOutput("t5_frozen_valid", 32'(out_valid), 32'd0);
    end
    applyStimulus(1'b1, 16'd30, 1'b1, 4'd1, 1'b1);
    checkOutput("t5_valid", 32'(out_valid), 32'd1);
    checkOutput("t5_data", 32'(out_data), 32'd60);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd1, 1'b1);
    checkOutput("t5_no_drop", 32'(drop), 32'd0);

    // Back-pressure in HOLD: beat rejected, drop set, result held
    sb_q.push_back('{data: 24'h42, ovf: 1'b0});
    applyStimulus(1'b1, 16'h30, 1'b1, 4'd2, 1'b0);
    applyStimulus(1'b1, 16'h12, 1'b1, 4'd2, 1'b0);
    checkOutput("t3_hold_valid", 32'(out_valid), 32'd1);
    in_data = 16'h99;
    #1;
    checkOutput("t3_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("t3_drop", 32'(drop), 32'd1);
    checkOutput("t3_held_data", 32'(out_data), 32'h42);
    checkOutput("t3_held_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd2, 1'b1);
    checkOutput("t3_released", 32'(out_valid), 32'd0);
    checkOutput("t3_drop_sticky", 32'(drop), 32'd1);

    // Carry-out: fits in 24 bits, wraps or clamps in the 16-bit instance
    sb_q.push_back('{data: 24'h010001, ovf: 1'b0});
    applyStimulus(1'b1, 16'hFFFF, 1'b1, 4'd2, 1'b1);
    applyStimulus(1'b1, 16'h0002, 1'b1, 4'd2, 1'b1);
    checkOutput("t4_n_valid", 32'(n_out_valid), 32'd1);
    checkOutput("t4_n_data", 32'(n_out_data), 32'(NARROW_EXP));
    checkOutput("t4_n_ovf", 32'(n_overflow), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd2, 1'b1);

    // Next group clears overflow
    sb_q.push_back('{data: 24'd3, ovf: 1'b0});
    applyStimulus(1'b1, 16'd3, 1'b1, 4'd0, 1'b1);
    checkOutput("t4_n_ovf_clear", 32'(n_overflow), 32'd0);
    checkOutput("t4_len0_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd0, 1'b1);

    // Asynchronous reset mid-group
    applyStimulus(1'b1, 16'd10, 1'b1, 4'd3, 1'b1);
    applyStimulus(1'b1, 16'd20, 1'b1, 4'd3, 1'b1);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t5r_out_data", 32'(out_data), 32'd0);
    checkOutput("t5r_out_valid", 32'(out_valid), 32'd0);
    checkOutput("t5r_in_ready", 32'(in_ready), 32'd1);
    checkOutput("t5r_drop", 32'(drop), 32'd0);
    checkOutput("t5r_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    sb_q.push_back('{data: 24'd4, ovf: 1'b0});
    applyStimulus(1'b1, 16'd4, 1'b1, 4'd1, 1'b1);
    checkOutput("t5r_fresh_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd1, 1'b1);
    applyStimulus(1'b0, 16'd0, 1'b1, 4'd1, 1'b1);
    checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
